// File: rtl/wb_periph_arbiter.sv
// Two-master Wishbone arbiter and address decoder for the peripheral slaves.
// One transfer in flight; unmapped addresses and slave timeouts return err.
module wb_periph_arbiter #(
    parameter int                     NUM_SLAVES     = 7,
    parameter int                     WB_AD_WIDTH    = 32,
    parameter int                     WB_DAT_WIDTH   = 32,
    parameter int                     SLAVE_ADDR_LSB = 12,
    parameter logic [WB_AD_WIDTH-1:0] BASE_ADDR      = 'h1000_0000,
    parameter int                     TIMEOUT        = 255
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    m0_cyc_i,
    input  logic                                    m0_stb_i,
    input  logic                                    m0_we_i,
    input  logic [WB_AD_WIDTH-1:0]                  m0_addr_i,
    input  logic [WB_DAT_WIDTH-1:0]                 m0_wdata_i,
    input  logic [WB_DAT_WIDTH/8-1:0]               m0_sel_i,
    output logic [WB_DAT_WIDTH-1:0]                 m0_rdata_o,
    output logic                                    m0_ack_o,
    output logic                                    m0_err_o,
    input  logic                                    m1_cyc_i,
    input  logic                                    m1_stb_i,
    input  logic                                    m1_we_i,
    input  logic [WB_AD_WIDTH-1:0]                  m1_addr_i,
    input  logic [WB_DAT_WIDTH-1:0]                 m1_wdata_i,
    input  logic [WB_DAT_WIDTH/8-1:0]               m1_sel_i,
    output logic [WB_DAT_WIDTH-1:0]                 m1_rdata_o,
    output logic                                    m1_ack_o,
    output logic                                    m1_err_o,
    output logic [NUM_SLAVES-1:0]                   wbm_slave_cyc_o,
    output logic [NUM_SLAVES-1:0]                   wbm_slave_stb_o,
    output logic [NUM_SLAVES-1:0]                   wbm_slave_we_o,
    output logic [NUM_SLAVES*WB_AD_WIDTH-1:0]       wbm_slave_addr_o,
    output logic [NUM_SLAVES*WB_DAT_WIDTH-1:0]      wbm_slave_wdata_o,
    output logic [NUM_SLAVES*(WB_DAT_WIDTH/8)-1:0]  wbm_slave_sel_o,
    input  logic [NUM_SLAVES-1:0]                   slave_wbm_ack_i,
    input  logic [NUM_SLAVES*WB_DAT_WIDTH-1:0]      slave_wbm_rdata_i,
    output logic                                    busy_o,
    output logic                                    timeout_o
);

    localparam int AW = WB_AD_WIDTH;
    localparam int DW = WB_DAT_WIDTH;
    localparam int SW = WB_DAT_WIDTH / 8;
    localparam int HI = SLAVE_ADDR_LSB + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic            grant_q;
    logic            last_grant_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   sel_q;
    logic            we_q;
    logic [2:0]      idx_q;
    logic [15:0]     cnt_q;
    logic            ack_q;
    logic            err_q;
    logic [DW-1:0]   rdata_q;

    logic            req0;
    logic            req1;
    logic            any_req;
    logic            grant_d;
    logic [AW-1:0]   in_addr;
    logic [DW-1:0]   in_wdata;
    logic [SW-1:0]   in_sel;
    logic            in_we;
    logic [2:0]      in_idx;
    logic            in_hit;
    logic            gnt_cyc;
    logic            slv_ack;
    logic [DW-1:0]   slv_rdata;
    logic            tmo_hit;
    logic            drive;
    logic            resp;
    logic [DW-1:0]   rd_out;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign any_req = req0 | req1;
    // On contention the master that was not granted last time wins.
    assign grant_d = (req0 & req1) ? ~last_grant_q : req1;

    assign in_addr  = grant_d ? m1_addr_i  : m0_addr_i;
    assign in_wdata = grant_d ? m1_wdata_i : m0_wdata_i;
    assign in_sel   = grant_d ? m1_sel_i   : m0_sel_i;
    assign in_we    = grant_d ? m1_we_i    : m0_we_i;
    assign in_idx   = in_addr[SLAVE_ADDR_LSB +: 3];
    assign in_hit   = (in_addr[AW-1:HI] == BASE_ADDR[AW-1:HI])
                    && (int'(in_idx) < NUM_SLAVES);

    assign gnt_cyc  = grant_q ? m1_cyc_i : m0_cyc_i;
    assign tmo_hit  = (cnt_q == 16'(TIMEOUT - 1));

    // Pick the ack and read data of the selected slave only.
    always_comb begin
        slv_ack   = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(idx_q) == i) begin
                slv_ack   = slave_wbm_ack_i[i];
                slv_rdata = slave_wbm_rdata_i[i*DW +: DW];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a master dropping cyc aborts silently.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = in_hit ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                if (!gnt_cyc) begin
                    state_d = S_IDLE;
                end else if (slv_ack || tmo_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Grant capture, timeout counter and response flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q   <= '0;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    if (any_req) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        addr_q       <= in_addr;
                        wdata_q      <= in_wdata;
                        sel_q        <= in_sel;
                        we_q         <= in_we;
                        idx_q        <= in_idx;
                        err_q        <= ~in_hit;
                    end
                end
                S_ACCESS: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (gnt_cyc) begin
                        if (slv_ack) begin
                            ack_q   <= 1'b1;
                            rdata_q <= slv_rdata;
                        end else if (tmo_hit) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign drive  = (state_q == S_ACCESS) && gnt_cyc;
    assign resp   = (state_q == S_RESP);
    assign rd_out = (resp && ack_q && !we_q) ? rdata_q : '0;

    // Outputs: slave strobes during ACCESS, master termination in RESP.
    always_comb begin
        busy_o            = (state_q != S_IDLE);
        timeout_o         = drive && !slv_ack && tmo_hit;
        m0_ack_o          = resp && ack_q && !grant_q;
        m0_err_o          = resp && err_q && !grant_q;
        m1_ack_o          = resp && ack_q && grant_q;
        m1_err_o          = resp && err_q && grant_q;
        m0_rdata_o        = grant_q ? '0 : rd_out;
        m1_rdata_o        = grant_q ? rd_out : '0;
        wbm_slave_cyc_o   = '0;
        wbm_slave_stb_o   = '0;
        wbm_slave_we_o    = '0;
        wbm_slave_addr_o  = '0;
        wbm_slave_wdata_o = '0;
        wbm_slave_sel_o   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (drive && int'(idx_q) == i) begin
                wbm_slave_cyc_o[i]              = 1'b1;
                wbm_slave_stb_o[i]              = 1'b1;
                wbm_slave_we_o[i]               = we_q;
                wbm_slave_addr_o[i*AW +: AW]    = addr_q;
                wbm_slave_wdata_o[i*DW +: DW]   = wdata_q;
                wbm_slave_sel_o[i*SW +: SW]     = sel_q;
            end
        end
    end

endmodule

// File: tb/tb_wb_periph_arbiter.sv
// Directed bench for wb_periph_arbiter with TIMEOUT = 4.
// Linear steps; expected values are hand-computed constants.
module tb_wb_periph_arbiter;

    localparam int NS = 7;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0]     m0_addr_i;
    logic [DW-1:0]     m0_wdata_i;
    logic [SW-1:0]     m0_sel_i;
    logic [DW-1:0]     m0_rdata_o;
    logic              m0_ack_o, m0_err_o;
    logic              m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0]     m1_addr_i;
    logic [DW-1:0]     m1_wdata_i;
    logic [SW-1:0]     m1_sel_i;
    logic [DW-1:0]     m1_rdata_o;
    logic              m1_ack_o, m1_err_o;
    logic [NS-1:0]     s_cyc, s_stb, s_we;
    logic [NS*AW-1:0]  s_addr;
    logic [NS*DW-1:0]  s_wdata;
    logic [NS*SW-1:0]  s_sel;
    logic [NS-1:0]     s_ack;
    logic [NS*DW-1:0]  s_rdata;
    logic              busy_o, timeout_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_periph_arbiter #(.TIMEOUT(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .m0_cyc_i          (m0_cyc_i),
        .m0_stb_i          (m0_stb_i),
        .m0_we_i           (m0_we_i),
        .m0_addr_i         (m0_addr_i),
        .m0_wdata_i        (m0_wdata_i),
        .m0_sel_i          (m0_sel_i),
        .m0_rdata_o        (m0_rdata_o),
        .m0_ack_o          (m0_ack_o),
        .m0_err_o          (m0_err_o),
        .m1_cyc_i          (m1_cyc_i),
        .m1_stb_i          (m1_stb_i),
        .m1_we_i           (m1_we_i),
        .m1_addr_i         (m1_addr_i),
        .m1_wdata_i        (m1_wdata_i),
        .m1_sel_i          (m1_sel_i),
        .m1_rdata_o        (m1_rdata_o),
        .m1_ack_o          (m1_ack_o),
        .m1_err_o          (m1_err_o),
        .wbm_slave_cyc_o   (s_cyc),
        .wbm_slave_stb_o   (s_stb),
        .wbm_slave_we_o    (s_we),
        .wbm_slave_addr_o  (s_addr),
        .wbm_slave_wdata_o (s_wdata),
        .wbm_slave_sel_o   (s_sel),
        .slave_wbm_ack_i   (s_ack),
        .slave_wbm_rdata_i (s_rdata),
        .busy_o            (busy_o),
        .timeout_o         (timeout_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        m0_addr_i = '0; m0_wdata_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        m1_addr_i = '0; m1_wdata_i = '0; m1_sel_i = '0;
        s_ack = '0;
        s_rdata = '0;
        step();
        step();
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_stb", 32'(s_stb), 32'd0);
        check("rst_cyc", 32'(s_cyc), 32'd0);
        check("rst_m0_ack", 32'(m0_ack_o), 32'd0);
        check("rst_m1_err", 32'(m1_err_o), 32'd0);
        check("rst_tmo", 32'(timeout_o), 32'd0);
        rst = 1'b0;

        // m0 read of UART0, ack two cycles after stb
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
        m0_addr_i = 32'h1000_1004; m0_sel_i = 4'hF;
        step();
        check("rd_stb", 32'(s_stb), 32'h02);
        check("rd_addr", s_addr[1*AW +: AW], 32'h1000_1004);
        check("rd_busy", 32'(busy_o), 32'd1);
        step();
        check("rd_wait_ack", 32'(m0_ack_o), 32'd0);
        step();
        s_ack[1] = 1'b1;
        s_rdata[1*DW +: DW] = 32'h0000_00A5;
        step();
        s_ack = '0;
        check("rd_ack", 32'(m0_ack_o), 32'd1);
        check("rd_data", m0_rdata_o, 32'h0000_00A5);
        check("rd_err", 32'(m0_err_o), 32'd0);
        check("rd_m1_ack", 32'(m1_ack_o), 32'd0);
        check("rd_resp_stb", 32'(s_stb), 32'd0);
        m0_cyc_i = 0; m0_stb_i = 0;
        step();
        check("rd_idle_busy", 32'(busy_o), 32'd0);
        check("rd_idle_data", m0_rdata_o, 32'd0);

        // contention right after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h1000_0000;
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0;
        m1_addr_i = 32'h1000_2000;
        step();
        check("arb1_stb", 32'(s_stb), 32'h01);
        s_ack[0] = 1'b1;
        s_rdata[0*DW +: DW] = 32'h11;
        step();
        s_ack = '0;
        check("arb1_m0_ack", 32'(m0_ack_o), 32'd1);
        check("arb1_m0_data", m0_rdata_o, 32'h11);
        check("arb1_m1_ack", 32'(m1_ack_o), 32'd0);
        check("arb1_m1_data", m1_rdata_o, 32'd0);
        m0_cyc_i = 0; m0_stb_i = 0;
        step();
        check("arb2_idle", 32'(busy_o), 32'd0);
        step();
        check("arb2_stb", 32'(s_stb), 32'h04);
        s_ack[2] = 1'b1;
        s_rdata[2*DW +: DW] = 32'h22;
        step();
        s_ack = '0;
        check("arb2_m1_ack", 32'(m1_ack_o), 32'd1);
        check("arb2_m1_data", m1_rdata_o, 32'h22);
        check("arb2_m0_ack", 32'(m0_ack_o), 32'd0);
        m1_cyc_i = 0; m1_stb_i = 0;
        step();
        m0_cyc_i = 1; m0_stb_i = 1;
        m1_cyc_i = 1; m1_stb_i = 1;
        step();
        check("arb3_stb", 32'(s_stb), 32'h01);
        s_ack[0] = 1'b1;
        step();
        s_ack = '0;
        check("arb3_m0_ack", 32'(m0_ack_o), 32'd1);
        check("arb3_m1_ack", 32'(m1_ack_o), 32'd0);
        m0_cyc_i = 0; m0_stb_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0;
        step();

        // unmapped writes from m1
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1;
        m1_addr_i = 32'h1000_7000; m1_wdata_i = 32'h1234_5678;
        step();
        check("miss7_err", 32'(m1_err_o), 32'd1);
        check("miss7_ack", 32'(m1_ack_o), 32'd0);
        check("miss7_stb", 32'(s_stb), 32'd0);
        check("miss7_data", m1_rdata_o, 32'd0);
        check("miss7_m0_err", 32'(m0_err_o), 32'd0);
        m1_cyc_i = 0; m1_stb_i = 0;
        step();
        check("miss7_idle", 32'(m1_err_o), 32'd0);
        m1_cyc_i = 1; m1_stb_i = 1;
        m1_addr_i = 32'h2000_0000;
        step();
        check("missb_err", 32'(m1_err_o), 32'd1);
        check("missb_stb", 32'(s_stb), 32'd0);
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        step();

        // SPI never acks: timeout after four strobe cycles
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
        m0_addr_i = 32'h1000_6000;
        step();
        check("tmo_stb1", 32'(s_stb), 32'h40);
        check("tmo_pulse1", 32'(timeout_o), 32'd0);
        step();
        step();
        check("tmo_stb3", 32'(s_stb), 32'h40);
        check("tmo_pulse3", 32'(timeout_o), 32'd0);
        step();
        check("tmo_stb4", 32'(s_stb), 32'h40);
        check("tmo_pulse4", 32'(timeout_o), 32'd1);
        step();
        check("tmo_drop", 32'(s_stb), 32'd0);
        check("tmo_pulse_off", 32'(timeout_o), 32'd0);
        check("tmo_err", 32'(m0_err_o), 32'd1);
        check("tmo_ack", 32'(m0_ack_o), 32'd0);
        check("tmo_data", m0_rdata_o, 32'd0);
        m0_cyc_i = 0; m0_stb_i = 0;
        step();

        // m0 abandons the cycle, slave acks late
        m0_cyc_i = 1; m0_stb_i = 1;
        m0_addr_i = 32'h1000_2000;
        step();
        check("abt_stb", 32'(s_stb), 32'h04);
        m0_cyc_i = 0; m0_stb_i = 0;
        #1;
        check("abt_stb_drop", 32'(s_stb), 32'd0);
        step();
        check("abt_idle", 32'(busy_o), 32'd0);
        s_ack[2] = 1'b1;
        s_rdata[2*DW +: DW] = 32'h33;
        step();
        check("abt_no_ack", 32'(m0_ack_o), 32'd0);
        check("abt_busy", 32'(busy_o), 32'd0);
        s_ack = '0;
        m1_cyc_i = 1; m1_stb_i = 1;
        m1_addr_i = 32'h1000_3000;
        step();
        check("abt_m1_stb", 32'(s_stb), 32'h08);
        s_ack[3] = 1'b1;
        s_rdata[3*DW +: DW] = 32'h44;
        step();
        s_ack = '0;
        check("abt_m1_ack", 32'(m1_ack_o), 32'd1);
        check("abt_m1_data", m1_rdata_o, 32'h44);
        m1_cyc_i = 0; m1_stb_i = 0;
        step();

        // reset during ACCESS, then a GPIO write completes
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
        m0_addr_i = 32'h1000_4010;
        m0_wdata_i = 32'hDEAD_BEEF; m0_sel_i = 4'h3;
        step();
        check("rsta_stb", 32'(s_stb), 32'h10);
        rst = 1'b1;
        step();
        check("rsta_stb0", 32'(s_stb), 32'd0);
        check("rsta_busy", 32'(busy_o), 32'd0);
        check("rsta_ack", 32'(m0_ack_o), 32'd0);
        check("rsta_err", 32'(m0_err_o), 32'd0);
        rst = 1'b0;
        step();
        check("wr_stb", 32'(s_stb), 32'h10);
        check("wr_we", 32'(s_we), 32'h10);
        check("wr_wdata", s_wdata[4*DW +: DW], 32'hDEAD_BEEF);
        check("wr_sel", 32'(s_sel[4*SW +: SW]), 32'h3);
        check("wr_addr", s_addr[4*AW +: AW], 32'h1000_4010);
        s_ack[4] = 1'b1;
        s_rdata[4*DW +: DW] = 32'h55;
        step();
        s_ack = '0;
        check("wr_ack", 32'(m0_ack_o), 32'd1);
        check("wr_data0", m0_rdata_o, 32'd0);
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        step();
        check("wr_idle", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
